// File: rtl/usb_msd_dma_seq_pkg.sv
// Shared types for the MSD DMA command sequencer: FSM states, queued
// command layout and direction encodings.
package usb_msd_dma_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CPL
  } seq_state_e;

  typedef struct packed {
    logic        dir;
    logic [31:0] adr;
    logic [15:0] len;
  } dma_cmd_t;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

endpackage

// File: rtl/usb_msd_cmd_fifo.sv
// Small synchronous FIFO holding posted DMA commands; flush empties it
// and discards a push made in the same cycle.
module usb_msd_cmd_fifo
  import usb_msd_dma_seq_pkg::*;
#(
  parameter int QDEPTH_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush,
  input  logic              push,
  input  dma_cmd_t          wr_data,
  input  logic              pop,
  output dma_cmd_t          rd_data,
  output logic              full,
  output logic              empty,
  output logic [QDEPTH_W:0] level
);

  localparam int DEPTH = 1 << QDEPTH_W;

  dma_cmd_t              mem [DEPTH];
  logic [QDEPTH_W-1:0]   wr_ptr;
  logic [QDEPTH_W-1:0]   rd_ptr;
  logic [QDEPTH_W:0]     cnt;
  logic                  wr_en;
  logic                  rd_en;

  assign rd_en = pop & !empty;
  // A full queue may still accept a write when the head leaves in the same cycle.
  assign wr_en = push & (!full | rd_en);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (cnt == (QDEPTH_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;

endmodule

// File: rtl/usb_msd_dma_sequencer.sv
// Command-queued sequencer that splits MSD transfers into FIFO-sized DMA
// chunks, supervises each chunk with a timeout and reports one completion.
module usb_msd_dma_sequencer
  import usb_msd_dma_seq_pkg::*;
#(
  parameter int QDEPTH_W   = 2,
  parameter int RX_CHUNK_W = 8,
  parameter int TX_CHUNK_W = 10,
  parameter int TMO_W      = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_dir_i,
  input  logic [31:0]       cmd_adr_i,
  input  logic [15:0]       cmd_len_i,
  input  logic              abort_i,
  output logic [31:0]       rx_dma_start_adr_o,
  output logic [15:0]       rx_dma_data_len_o,
  output logic              rx_dma_start_o,
  input  logic              rx_dma_idle_i,
  input  logic              rx_dma_done_i,
  output logic [31:0]       tx_dma_start_adr_o,
  output logic [15:0]       tx_dma_data_len_o,
  output logic              tx_dma_start_o,
  input  logic              tx_dma_idle_i,
  input  logic              tx_dma_done_i,
  output logic              cpl_stb_o,
  output logic              cpl_dir_o,
  output logic              cpl_err_o,
  output logic [15:0]       cpl_len_o,
  output logic              busy_o,
  output logic [QDEPTH_W:0] q_level_o
);

  seq_state_e        state_q, state_d;
  dma_cmd_t          push_cmd, head;
  logic              q_full, q_empty, q_push, q_pop;
  logic              cur_dir, cur_err;
  logic [31:0]       cur_adr;
  logic [15:0]       rem, done_cnt, chunk, chunk_d;
  logic [16:0]       chunk_lim;
  logic [TMO_W-1:0]  tmr;
  logic              head_idle, cur_done, tmo_hit, in_xfer;

  assign cmd_ready_o  = !q_full;
  assign q_push       = cmd_valid_i & cmd_ready_o;
  assign push_cmd.dir = cmd_dir_i;
  assign push_cmd.adr = cmd_adr_i;
  assign push_cmd.len = cmd_len_i;
  assign head_idle    = (head.dir == DIR_TX) ? tx_dma_idle_i : rx_dma_idle_i;
  assign q_pop        = (state_q == S_IDLE) & !q_empty & head_idle & !abort_i;
  assign cur_done     = (cur_dir == DIR_TX) ? tx_dma_done_i : rx_dma_done_i;
  assign tmo_hit      = &tmr;
  assign in_xfer      = (state_q == S_LOAD) | (state_q == S_START) | (state_q == S_WAIT);

  usb_msd_cmd_fifo #(.QDEPTH_W(QDEPTH_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush   (abort_i),
    .push    (q_push),
    .wr_data (push_cmd),
    .pop     (q_pop),
    .rd_data (head),
    .full    (q_full),
    .empty   (q_empty),
    .level   (q_level_o)
  );

  always_comb begin
    chunk_lim = (cur_dir == DIR_TX) ? (17'd1 << TX_CHUNK_W) : (17'd1 << RX_CHUNK_W);
    chunk_d   = ({1'b0, rem} < chunk_lim) ? rem : chunk_lim[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (q_pop) state_d = (head.len == '0) ? S_CPL : S_LOAD;
      S_LOAD:  state_d = abort_i ? S_CPL : S_START;
      S_START: state_d = abort_i ? S_CPL : S_WAIT;
      S_WAIT: begin
        if (abort_i)       state_d = S_CPL;
        else if (cur_done) state_d = (rem == chunk) ? S_CPL : S_LOAD;
        else if (tmo_hit)  state_d = S_CPL;
      end
      S_CPL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-command context and the per-direction DMA programming registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_dir            <= DIR_RX;
      cur_err            <= 1'b0;
      cur_adr            <= '0;
      rem                <= '0;
      done_cnt           <= '0;
      chunk              <= '0;
      tmr                <= '0;
      rx_dma_start_adr_o <= '0;
      rx_dma_data_len_o  <= '0;
      tx_dma_start_adr_o <= '0;
      tx_dma_data_len_o  <= '0;
    end else begin
      if (q_pop) begin
        cur_dir  <= head.dir;
        cur_adr  <= head.adr;
        rem      <= head.len;
        done_cnt <= '0;
        cur_err  <= 1'b0;
      end
      if (state_q == S_LOAD) begin
        chunk <= chunk_d;
        tmr   <= '0;
        if (cur_dir == DIR_TX) begin
          tx_dma_start_adr_o <= cur_adr;
          tx_dma_data_len_o  <= chunk_d;
        end else begin
          rx_dma_start_adr_o <= cur_adr;
          rx_dma_data_len_o  <= chunk_d;
        end
      end
      if (state_q == S_WAIT) begin
        tmr <= tmr + 1'b1;
        if (!abort_i && cur_done) begin
          rem      <= rem - chunk;
          cur_adr  <= cur_adr + {16'd0, chunk};
          done_cnt <= done_cnt + chunk;
        end else if (!abort_i && tmo_hit) begin
          cur_err <= 1'b1;
        end
      end
      if (abort_i && in_xfer) cur_err <= 1'b1;
    end
  end

  always_comb begin
    rx_dma_start_o = (state_q == S_START) && (cur_dir == DIR_RX);
    tx_dma_start_o = (state_q == S_START) && (cur_dir == DIR_TX);
    cpl_stb_o      = (state_q == S_CPL);
    cpl_dir_o      = (state_q == S_CPL) ? cur_dir : 1'b0;
    cpl_err_o      = (state_q == S_CPL) ? cur_err : 1'b0;
    cpl_len_o      = (state_q == S_CPL) ? done_cnt : 16'd0;
    busy_o         = (state_q != S_IDLE) || !q_empty;
  end

endmodule

// File: tb/tb_usb_msd_dma_sequencer.sv
// Scoreboard bench for usb_msd_dma_sequencer with a behavioural DMA model
// that answers each start with a done strobe unless told to withhold it.
module tb_usb_msd_dma_sequencer;

  localparam int QDEPTH_W = 2;
  localparam int DLY      = 3;

  typedef struct {
    logic        dir;
    logic [31:0] adr;
    logic [15:0] len;
    bit          gap;
    int          lat;
  } exp_start_t;

  typedef struct {
    logic        dir;
    logic        err;
    logic [15:0] len;
    int          lat;
    bit          tmo;
  } exp_cpl_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic              cmd_dir_i = 1'b0;
  logic [31:0]       cmd_adr_i = '0;
  logic [15:0]       cmd_len_i = '0;
  logic              abort_i = 1'b0;
  logic [31:0]       rx_dma_start_adr_o, tx_dma_start_adr_o;
  logic [15:0]       rx_dma_data_len_o, tx_dma_data_len_o;
  logic              rx_dma_start_o, tx_dma_start_o;
  logic              rx_dma_idle_i = 1'b1;
  logic              tx_dma_idle_i = 1'b1;
  logic              rx_dma_done_i, tx_dma_done_i;
  logic              cpl_stb_o, cpl_dir_o, cpl_err_o;
  logic [15:0]       cpl_len_o;
  logic              busy_o;
  logic [QDEPTH_W:0] q_level_o;

  logic model_rx_done = 1'b0;
  logic model_tx_done = 1'b0;
  logic spur_rx_done  = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_push_cyc = 0;
  int last_start_cyc = 0;
  int last_done_cyc = 0;
  int rx_pend = 0;
  int tx_pend = 0;
  int rx_starts = 0;
  int hold_idx = -1;

  exp_start_t exp_start_q[$];
  exp_cpl_t   exp_cpl_q[$];

  assign rx_dma_done_i = model_rx_done | spur_rx_done;
  assign tx_dma_done_i = model_tx_done;

  usb_msd_dma_sequencer #(
    .QDEPTH_W(QDEPTH_W), .RX_CHUNK_W(8), .TX_CHUNK_W(10), .TMO_W(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_dir_i(cmd_dir_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .abort_i(abort_i),
    .rx_dma_start_adr_o(rx_dma_start_adr_o), .rx_dma_data_len_o(rx_dma_data_len_o),
    .rx_dma_start_o(rx_dma_start_o), .rx_dma_idle_i(rx_dma_idle_i), .rx_dma_done_i(rx_dma_done_i),
    .tx_dma_start_adr_o(tx_dma_start_adr_o), .tx_dma_data_len_o(tx_dma_data_len_o),
    .tx_dma_start_o(tx_dma_start_o), .tx_dma_idle_i(tx_dma_idle_i), .tx_dma_done_i(tx_dma_done_i),
    .cpl_stb_o(cpl_stb_o), .cpl_dir_o(cpl_dir_o), .cpl_err_o(cpl_err_o), .cpl_len_o(cpl_len_o),
    .busy_o(busy_o), .q_level_o(q_level_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // DMA model: done arrives DLY cycles after a start, unless that RX start is the held one.
  always @(posedge clk_i) begin
    #1;
    model_rx_done = 1'b0;
    model_tx_done = 1'b0;
    if (rx_pend > 0) begin
      rx_pend--;
      if (rx_pend == 0) model_rx_done = 1'b1;
    end
    if (tx_pend > 0) begin
      tx_pend--;
      if (tx_pend == 0) model_tx_done = 1'b1;
    end
    if (rx_dma_start_o) begin
      if (rx_starts != hold_idx) rx_pend = DLY;
      rx_starts++;
    end
    if (tx_dma_start_o) tx_pend = DLY;
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    exp_start_t s;
    exp_cpl_t   c;
    if (!rst_i) begin
      if (rx_dma_start_o || tx_dma_start_o) begin
        checkOutput("start_expected", 32'(exp_start_q.size() != 0), 32'd1);
        checkOutput("single_start", 32'(rx_dma_start_o & tx_dma_start_o), 32'd0);
        if (exp_start_q.size() != 0) begin
          s = exp_start_q.pop_front();
          checkOutput("start_dir", 32'(tx_dma_start_o), 32'(s.dir));
          checkOutput("start_adr", tx_dma_start_o ? tx_dma_start_adr_o : rx_dma_start_adr_o, s.adr);
          checkOutput("start_len", 32'(tx_dma_start_o ? tx_dma_data_len_o : rx_dma_data_len_o), 32'(s.len));
          if (s.gap) checkOutput("start_gap", 32'(cyc - last_done_cyc), 32'd2);
          if (s.lat != 0) checkOutput("start_lat", 32'(cyc - last_push_cyc), 32'(s.lat));
        end
        last_start_cyc = cyc;
      end
      if (cpl_stb_o) begin
        checkOutput("cpl_expected", 32'(exp_cpl_q.size() != 0), 32'd1);
        if (exp_cpl_q.size() != 0) begin
          c = exp_cpl_q.pop_front();
          checkOutput("cpl_dir", 32'(cpl_dir_o), 32'(c.dir));
          checkOutput("cpl_err", 32'(cpl_err_o), 32'(c.err));
          checkOutput("cpl_len", 32'(cpl_len_o), 32'(c.len));
          if (c.lat != 0) checkOutput("cpl_lat", 32'(cyc - last_push_cyc), 32'(c.lat));
          if (c.tmo) checkOutput("cpl_tmo_lat",
                                 32'((cyc - last_start_cyc >= 16) && (cyc - last_start_cyc <= 17)), 32'd1);
        end
      end
      if (model_rx_done || model_tx_done) last_done_cyc = cyc;
    end
  end

  function automatic void expectStart(input logic d, input logic [31:0] a, input logic [15:0] l,
                                      input bit gap, input int lat);
    exp_start_t s;
    s.dir = d; s.adr = a; s.len = l; s.gap = gap; s.lat = lat;
    exp_start_q.push_back(s);
  endfunction

  function automatic void expectCpl(input logic d, input logic e, input logic [15:0] l,
                                    input int lat, input bit tmo);
    exp_cpl_t c;
    c.dir = d; c.err = e; c.len = l; c.lat = lat; c.tmo = tmo;
    exp_cpl_q.push_back(c);
  endfunction

  // Drives one command until accepted; when expect_ok, the chunked
  // success expectations are derived here and pushed to the scoreboard.
  task automatic applyStimulus(input logic d, input logic [31:0] a, input logic [15:0] l,
                               input bit expect_ok, input int first_lat);
    int waited = 0;
    int rem;
    int ch;
    logic [31:0] ca;
    cmd_valid_i = 1'b1; cmd_dir_i = d; cmd_adr_i = a; cmd_len_i = l;
    while (!cmd_ready_o && waited < 300) begin
      @(posedge clk_i); #1; waited++;
    end
    checkOutput("push_accepted", 32'(cmd_ready_o), 32'd1);
    last_push_cyc = cyc;
    if (expect_ok) begin
      rem = int'(l); ca = a;
      while (rem > 0) begin
        ch = (rem < (d ? 1024 : 256)) ? rem : (d ? 1024 : 256);
        expectStart(d, ca, 16'(ch), rem != int'(l), (rem == int'(l)) ? first_lat : 0);
        ca = ca + 32'(ch); rem = rem - ch;
      end
      expectCpl(d, 1'b0, l, (l == 16'd0) ? first_lat : 0, 1'b0);
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int maxc);
    int n = 0;
    while ((exp_start_q.size() != 0 || exp_cpl_q.size() != 0 || busy_o) && n < maxc) begin
      @(posedge clk_i); #1; n++;
    end
    checkOutput(tag, 32'(exp_start_q.size() + exp_cpl_q.size() + 32'(busy_o)), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("rst_level", 32'(q_level_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_outs", 32'({rx_dma_start_o, tx_dma_start_o, cpl_stb_o, cpl_err_o}), 32'd0);
    checkOutput("rst_rx_adr", rx_dma_start_adr_o, 32'd0);
    checkOutput("rst_tx_len", 32'(tx_dma_data_len_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    $display("[TB] multi-chunk RX");
    applyStimulus(1'b0, 32'h1000, 16'd600, 1'b1, 3);
    waitDrain("drain_rx600", 200);

    $display("[TB] back-to-back TX then RX");
    applyStimulus(1'b1, 32'h8000, 16'd1024, 1'b1, 0);
    applyStimulus(1'b0, 32'h9000, 16'd4, 1'b1, 0);
    waitDrain("drain_txrx", 200);

    $display("[TB] queue fill while RX DMA busy");
    rx_dma_idle_i = 1'b0;
    base = rx_starts;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h4000 + 32'(i * 64), 16'(8 * (i + 1)), 1'b1, 0);
    checkOutput("full_ready", 32'(cmd_ready_o), 32'd0);
    checkOutput("full_level", 32'(q_level_o), 32'd4);
    repeat (10) @(posedge clk_i);
    #1;
    checkOutput("no_start_not_idle", 32'(rx_starts - base), 32'd0);
    rx_dma_idle_i = 1'b1;
    applyStimulus(1'b0, 32'h5000, 16'd300, 1'b1, 0);
    waitDrain("drain_fill", 400);

    $display("[TB] zero length");
    applyStimulus(1'b1, 32'h6000, 16'd0, 1'b1, 2);
    waitDrain("drain_len0", 50);

    $display("[TB] chunk timeout");
    hold_idx = rx_starts + 1;
    expectStart(1'b0, 32'h2000, 16'd256, 1'b0, 0);
    expectStart(1'b0, 32'h2100, 16'd44, 1'b1, 0);
    expectCpl(1'b0, 1'b1, 16'd256, 0, 1'b1);
    applyStimulus(1'b0, 32'h2000, 16'd300, 1'b0, 0);
    applyStimulus(1'b0, 32'h2400, 16'd8, 1'b1, 0);
    waitDrain("drain_tmo", 300);

    $display("[TB] abort in second chunk");
    hold_idx = rx_starts + 1;
    expectStart(1'b0, 32'h3000, 16'd256, 1'b0, 0);
    expectStart(1'b0, 32'h3100, 16'd256, 1'b1, 0);
    expectCpl(1'b0, 1'b1, 16'd256, 0, 1'b0);
    applyStimulus(1'b0, 32'h3000, 16'd600, 1'b0, 0);
    applyStimulus(1'b0, 32'h3400, 16'd16, 1'b0, 0);
    applyStimulus(1'b1, 32'h3800, 16'd16, 1'b0, 0);
    n = 0;
    while (rx_starts <= hold_idx && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    checkOutput("abort_reached_chunk2", 32'(rx_starts > hold_idx), 32'd1);
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("abort_pre_level", 32'(q_level_o), 32'd2);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_level", 32'(q_level_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    hold_idx = -1;
    spur_rx_done = 1'b1;
    @(posedge clk_i); #1;
    spur_rx_done = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    checkOutput("spur_busy", 32'(busy_o), 32'd0);
    waitDrain("drain_abort", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/usb_msd_dma_sequencer.md
Name: usb_msd_dma_sequencer

Overview:
- Command-queued sequencer for the MSD RX/TX DMA engines (`wb_32bit_dma_8bit_fifo_reader` / `..._writer`).
- Firmware or the SCSI layer posts transfers of arbitrary length (up to 64 KiB − 1 B).
- The block splits each transfer into chunks no larger than the FIFO-depth limit of the target direction, then drives start address, length and start strobe per chunk.
- It waits for each DMA done strobe, enforces a per-chunk timeout and reports one completion per command. It replaces the per-chunk SFR writes made today by software.

Parameters:
- QDEPTH_W, 2, log2 of the command queue depth (4 entries).
- RX_CHUNK_W, 8, max RX chunk = 2**RX_CHUNK_W bytes (matches RX_DPTH_W).
- TX_CHUNK_W, 10, max TX chunk = 2**TX_CHUNK_W bytes.
- TMO_W, 20, width of the per-chunk timeout counter.

Ports:
- clk_i  in  1  Wishbone clock.
- rst_i  in  1  sync active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  queue not full.
- cmd_dir_i  in  1  0 = RX (USB→mem), 1 = TX (mem→USB).
- cmd_adr_i  in  32  byte start address, word aligned.
- cmd_len_i  in  16  byte count.
- abort_i  in  1  flush queue and current command.
- rx_dma_start_adr_o  out  32  chunk address to RX DMA.
- rx_dma_data_len_o  out  16  chunk length to RX DMA.
- rx_dma_start_o  out  1  1-cycle start strobe.
- rx_dma_idle_i  in  1  RX DMA idle.
- rx_dma_done_i  in  1  RX DMA done strobe.
- tx_dma_start_adr_o, tx_dma_data_len_o, tx_dma_start_o, tx_dma_idle_i, tx_dma_done_i: same as the RX set, for TX.
- cpl_stb_o  out  1  command completed (1 cycle).
- cpl_dir_o  out  1  direction of completed command.
- cpl_err_o  out  1  1 = timeout or abort.
- cpl_len_o  out  16  bytes actually transferred.
- busy_o  out  1  state ≠ IDLE or queue non-empty.
- q_level_o  out  QDEPTH_W+1  queue occupancy.

Behaviour:
- Clock and reset: single clock `clk_i`. Reset `rst_i` is synchronous and active-high.
- Reset values: all outputs 0, except `cmd_ready_o` = 1. Queue empty, state IDLE.
- Queue:
  - FIFO of {dir, adr, len}; a write happens when `cmd_valid_i & cmd_ready_o`.
  - `cmd_ready_o` = !full.
  - Push and pop in the same cycle are allowed when full; `q_level_o` is unchanged in that case.
- State machine: IDLE, LOAD, START, WAIT, CPL.
- IDLE:
  - Pops when the queue is non-empty and the `*_dma_idle_i` of the head's direction is 1.
  - Latches cur_dir, cur_adr, rem = len, done_cnt = 0.
  - If len == 0, goes to CPL (no DMA start, err = 0). Otherwise goes to LOAD.
- LOAD:
  - chunk = min(rem, 2**CHUNK_W(dir)).
  - Registers chunk onto the selected direction's adr/len outputs. The other direction's outputs are unchanged.
  - Clears the timer. Goes to START.
- START:
  - The selected `*_dma_start_o` is 1 for exactly this cycle. Goes to WAIT.
  - Adr/len outputs are held stable from LOAD until the next LOAD.
- WAIT:
  - The timer increments each cycle.
  - On the done strobe of cur_dir: rem −= chunk, cur_adr += chunk (32-bit wrap permitted), done_cnt += chunk. If rem == 0, go to CPL; otherwise go to LOAD.
  - Timer all-ones without done: err = 1, go to CPL.
  - If done and timeout occur in the same cycle, done wins.
- CPL:
  - `cpl_stb_o` = 1 for one cycle, with `cpl_dir_o`, `cpl_err_o`, and `cpl_len_o` = done_cnt. Returns to IDLE.
- Done strobes are ignored outside WAIT, and a done strobe for the non-current direction is always ignored.
- abort_i (any state):
  - Queue is flushed the next cycle.
  - If in LOAD, START or WAIT, go to CPL with err = 1 and the bytes counted so far.
  - If in IDLE or CPL, no extra completion is generated.
  - A push in the abort cycle is dropped.
- Latency: from push into an empty queue at cycle N with an idle DMA, pop at N+1, LOAD at N+2, start strobe at N+3.
- Commands are executed strictly in order; there is no RX/TX interleaving.

Decomposition:
- Package `usb_msd_dma_seq_pkg`: `seq_state_e` enum, `dma_cmd_t` packed struct {dir, adr, len}, DIR_RX/DIR_TX constants.
- Sub-module `usb_msd_cmd_fifo`: synchronous FIFO of `dma_cmd_t`, QDEPTH_W parameter, flush input, level output.

Test Plan:
- RX cmd adr 0x1000, len 600 (RX_CHUNK 256) → starts at 0x1000/256, 0x1100/256, 0x1200/88; each start follows the previous done by 2 cycles; cpl len 600, err 0.
- TX cmd len 1024, then RX cmd len 4, back-to-back → TX single chunk 1024, then RX chunk 4; two completions in order, dir 1 then 0.
- Push 5 cmds while RX DMA idle = 0 → `cmd_ready_o` drops after 4, `q_level_o` = 4; no start strobe until idle = 1.
- Len 0 cmd → no start strobe, cpl_stb 2 cycles after push, cpl_len 0.
- TMO_W = 4, done withheld → cpl_err 1 sixteen cycles after start, cpl_len = chunks completed before it; next queued cmd then proceeds.
- abort_i during WAIT of 2nd chunk (chunk 256) with 2 cmds queued → cpl err 1 len 256, `q_level_o` = 0, busy_o = 0 after CPL; spurious later done ignored.
